// File: rtl/imem_loader.sv
// Instruction-memory loader: unpacks a length/data/checksum byte frame into 32-bit
// words on the imem write port and holds the core in reset until the image verifies.
module imem_loader #(
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned DEPTH   = 8192,
  parameter int unsigned CNT_W   = 14,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              load_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [CNT_W-1:0]  words_loaded
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [7:0]          csum_q, csum_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [23:0]         word_q, word_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rx_ready_q, rx_ready_d;
  logic                core_hold_q, core_hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                accept;

  assign rx_ready     = rx_ready_q;
  assign imem_we      = we_q;
  assign imem_waddr   = waddr_q;
  assign imem_wdata   = wdata_q;
  assign core_hold    = core_hold_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign words_loaded = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LEN0;
      len_q       <= '0;
      csum_q      <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      idle_q      <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rx_ready_q  <= 1'b1;
      core_hold_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      csum_q      <= csum_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      idle_q      <= idle_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rx_ready_q  <= rx_ready_d;
      core_hold_q <= core_hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    csum_d     = csum_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    idle_d     = idle_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    accept     = rx_valid && rx_ready_q;

    case (state_q)
      S_LEN0: begin
        if (accept) begin
          len_d   = {8'h00, rx_data};
          csum_d  = rx_data;
          state_d = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d      = {rx_data, len_q[7:0]};
          csum_d     = csum_q ^ rx_data;
          byte_idx_d = '0;
          cnt_d      = '0;
          if (32'(len_d) > DEPTH)  state_d = S_ERR;
          else if (len_d == 16'd0) state_d = S_CSUM;
          else                     state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d     = csum_q ^ rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0:    word_d[7:0]   = rx_data;
            2'd1:    word_d[15:8]  = rx_data;
            2'd2:    word_d[23:16] = rx_data;
            default: begin
              // Fourth byte completes the word; write strobe lands next cycle.
              we_d    = 1'b1;
              waddr_d = ADDR_W'(cnt_q);
              wdata_d = {rx_data, word_q};
              cnt_d   = cnt_q + CNT_W'(1);
              if (32'(cnt_q) + 32'd1 == 32'(len_q)) state_d = S_CSUM;
            end
          endcase
        end
      end
      S_CSUM: begin
        if (accept) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: begin
        if (load_req) begin
          state_d    = S_LEN0;
          csum_d     = '0;
          cnt_d      = '0;
          byte_idx_d = '0;
        end
      end
      default: state_d = S_LEN0;
    endcase

    // Mid-frame idle watchdog; an accepted byte always beats expiry.
    if (state_q inside {S_LEN1, S_DATA, S_CSUM}) begin
      if (accept) begin
        idle_d = '0;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
        if (32'(idle_d) >= TIMEOUT) state_d = S_ERR;
      end
    end else begin
      idle_d = '0;
    end

    rx_ready_d  = state_d inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
    core_hold_d = (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frame-level byte-position model compared every cycle,
// directed scenarios with literal expectations, then randomized frames.
module tb_imem_loader;
  localparam int unsigned ADDR_W  = 15;
  localparam int unsigned DEPTH   = 8192;
  localparam int unsigned CNT_W   = 14;
  localparam int unsigned TIMEOUT = 16;

  localparam int ST_LOAD = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready;
  logic              load_req = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              load_done;
  logic              load_err;
  logic [CNT_W-1:0]  words_loaded;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .load_req(load_req), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: everything follows from the position of each byte in the frame.
  bit         m_valid = 1'b0;
  int         m_status, m_pos, m_len, m_idle, m_words, m_addr;
  logic [7:0] m_xor;
  logic [7:0] m_wb [4];
  bit         m_we;
  logic [31:0] m_data;

  always @(posedge clk) begin : model
    int off;
    logic [7:0] b;
    m_we = 1'b0;
    if (reset) begin
      m_valid = 1'b1; m_status = ST_LOAD; m_pos = 0; m_len = 0;
      m_idle = 0; m_words = 0; m_xor = 8'h00;
    end else if (m_valid) begin
      if (m_status == ST_LOAD) begin
        if (rx_valid) begin
          b = rx_data;
          m_idle = 0;
          if (m_pos == 0) begin
            m_len = int'(b); m_xor = b;
          end else if (m_pos == 1) begin
            m_len = m_len + 256 * int'(b); m_xor = m_xor ^ b;
            if (m_len > int'(DEPTH)) m_status = ST_ERR;
          end else if (m_pos < 2 + 4 * m_len) begin
            off = (m_pos - 2) % 4;
            m_xor = m_xor ^ b;
            if (off == 3) begin
              m_we = 1'b1; m_addr = (m_pos - 2) / 4;
              m_data = {b, m_wb[2], m_wb[1], m_wb[0]};
              m_words++;
            end else begin
              m_wb[off] = b;
            end
          end else begin
            m_status = (b == m_xor) ? ST_DONE : ST_ERR;
          end
          m_pos++;
        end else if (m_pos > 0) begin
          m_idle++;
          if (m_idle >= int'(TIMEOUT)) m_status = ST_ERR;
        end
      end else if (load_req) begin
        m_status = ST_LOAD; m_pos = 0; m_len = 0; m_idle = 0; m_words = 0; m_xor = 8'h00;
      end
    end
  end

  logic [ADDR_W-1:0] wr_addr [$];
  logic [31:0]       wr_data [$];

  always @(negedge clk) begin : compare
    if (m_valid) begin
      check("rx_ready",     32'(rx_ready),     32'(m_status == ST_LOAD));
      check("core_hold",    32'(core_hold),    32'(m_status != ST_DONE));
      check("load_done",    32'(load_done),    32'(m_status == ST_DONE));
      check("load_err",     32'(load_err),     32'(m_status == ST_ERR));
      check("imem_we",      32'(imem_we),      32'(m_we));
      check("words_loaded", 32'(words_loaded), 32'(m_words));
      if (m_we) begin
        check("imem_waddr", 32'(imem_waddr), 32'(m_addr));
        check("imem_wdata", imem_wdata, m_data);
      end
    end
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_waddr);
      wr_data.push_back(imem_wdata);
    end
  end

  logic [7:0] frame [$];
  logic [7:0] basic_img [10] = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                                 8'hEF, 8'hBE, 8'hAD, 8'hDE};

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input logic lr);
    idle(gap);
    rx_valid = 1'b1; rx_data = b; load_req = lr;
    step();
    rx_valid = 1'b0; load_req = 1'b0;
  endtask

  task automatic pulse_req();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  task automatic send_frame(input int gap_at, input int gap_len);
    foreach (frame[i]) send_byte(frame[i], (i == gap_at) ? gap_len : 0, 1'b0);
  endtask

  task automatic load_basic(input logic [7:0] last);
    frame.delete();
    foreach (basic_img[i]) frame.push_back(basic_img[i]);
    frame.push_back(last);
  endtask

  task automatic fix_csum();
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < frame.size() - 1; i++) x = x ^ frame[i];
    frame[frame.size() - 1] = x;
  endtask

  task automatic build_frame(input int n, input bit bad);
    logic [15:0] n16;
    n16 = 16'(n);
    frame.delete();
    frame.push_back(n16[7:0]);
    frame.push_back(n16[15:8]);
    for (int i = 0; i < 4 * n; i++) frame.push_back(8'($urandom));
    frame.push_back(8'h00);
    fix_csum();
    if (bad) frame[frame.size() - 1] = frame[frame.size() - 1] ^ 8'(1 + $urandom % 255);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_basic_writes();
    check("basic_write_count", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("basic_addr0", 32'(wr_addr[0]), 32'd0);
      check("basic_data0", wr_data[0], 32'h12345678);
      check("basic_addr1", 32'(wr_addr[1]), 32'd1);
      check("basic_data1", wr_data[1], 32'hDEADBEEF);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not end, got running expected finished");
    $fatal(1);
  end

  initial begin : main
    int n, gap, wc;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    check("reset_core_hold", 32'(core_hold), 32'd1);
    check("reset_load_done", 32'(load_done), 32'd0);
    check("reset_load_err",  32'(load_err),  32'd0);
    check("reset_we",        32'(imem_we),   32'd0);
    check("reset_words",     32'(words_loaded), 32'd0);
    check("reset_rx_ready",  32'(rx_ready),  32'd1);

    // Basic image, back-to-back
    clear_log();
    load_basic(8'h28);
    send_frame(-1, 0);
    idle(2);
    check_basic_writes();
    check("basic_words", 32'(words_loaded), 32'd2);
    check("basic_done",  32'(load_done), 32'd1);
    check("basic_hold",  32'(core_hold), 32'd0);

    // Bad checksum
    pulse_req();
    clear_log();
    load_basic(8'h29);
    send_frame(-1, 0);
    idle(2);
    check_basic_writes();
    check("badcs_err",   32'(load_err), 32'd1);
    check("badcs_hold",  32'(core_hold), 32'd1);
    check("badcs_ready", 32'(rx_ready), 32'd0);

    // Oversize length
    pulse_req();
    clear_log();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h20, 0, 1'b0);
    check("oversize_err",   32'(load_err), 32'd1);
    check("oversize_ready", 32'(rx_ready), 32'd0);
    idle(3);
    check("oversize_writes", 32'(wr_addr.size()), 32'd0);

    // Empty image
    pulse_req();
    clear_log();
    frame.delete();
    frame.push_back(8'h00); frame.push_back(8'h00); frame.push_back(8'h00);
    send_frame(-1, 0);
    idle(2);
    check("empty_done",   32'(load_done), 32'd1);
    check("empty_words",  32'(words_loaded), 32'd0);
    check("empty_writes", 32'(wr_addr.size()), 32'd0);

    // Gap of TIMEOUT-1 survives, gap of TIMEOUT aborts
    build_frame(3, 1'b0);
    frame[2] = 8'h11;
    fix_csum();
    pulse_req();
    send_frame(3, 15);
    idle(2);
    check("gap15_done", 32'(load_done), 32'd1);
    check("gap15_words", 32'(words_loaded), 32'd3);
    pulse_req();
    send_frame(3, 16);
    idle(2);
    check("gap16_err", 32'(load_err), 32'd1);

    // Restart after error
    pulse_req();
    clear_log();
    load_basic(8'h28);
    send_frame(-1, 0);
    idle(2);
    check("restart_done", 32'(load_done), 32'd1);
    check_basic_writes();

    // Reset coinciding with the word-completing byte
    pulse_req();
    clear_log();
    for (int i = 0; i < 5; i++) send_byte(frame[i], 0, 1'b0);
    rx_valid = 1'b1; rx_data = 8'h12; reset = 1'b1;
    step();
    rx_valid = 1'b0; reset = 1'b0;
    check("rstmid_hold",  32'(core_hold), 32'd1);
    check("rstmid_ready", 32'(rx_ready), 32'd1);
    check("rstmid_words", 32'(words_loaded), 32'd0);
    idle(3);
    check("rstmid_writes", 32'(wr_addr.size()), 32'd0);
    send_frame(-1, 0);
    idle(2);
    check("rstmid_reload_done", 32'(load_done), 32'd1);
    check_basic_writes();

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      pulse_req();
      idle($urandom_range(0, 20));
      if ($urandom % 10 == 0) begin
        n = int'(DEPTH) + 1 + int'($urandom_range(0, 100));
        frame.delete();
        frame.push_back(8'(n)); frame.push_back(8'(n >> 8));
        for (int i = 0; i < 3; i++) frame.push_back(8'($urandom));
      end else begin
        build_frame(int'($urandom_range(0, 5)), ($urandom % 6) == 0);
      end
      foreach (frame[i]) begin
        gap = ($urandom % 10 == 0) ? int'($urandom_range(1, 18)) : 0;
        send_byte(frame[i], gap, ($urandom % 12) == 0);
      end
      idle(2);
    end
    wc = n_checks;
    check("random_ran", 32'(wc > 0), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
